// File: rtl/iiitb_coin_acceptor_if.sv
// Purpose: coin-slot sensor, downstream busy and coin-code signals of the acceptor.
// Latency: none; this is a plain signal bundle.
// Backpressure: vend_busy travels master->slave; the acceptor holds at most one coin while it is high.
interface iiitb_coin_acceptor_if;
  logic       coin5_raw;
  logic       coin10_raw;
  logic       vend_busy;
  logic [1:0] in_code;
  logic       pending;
  logic       reject;

  // Sensor/machine side: drives raw levels and busy, observes the coin code.
  modport master (
    output coin5_raw,
    output coin10_raw,
    output vend_busy,
    input  in_code,
    input  pending,
    input  reject
  );

  // Acceptor side.
  modport slave (
    input  coin5_raw,
    input  coin10_raw,
    input  vend_busy,
    output in_code,
    output pending,
    output reject
  );
endinterface

// File: rtl/iiitb_coin_acceptor.sv
// Purpose: synchronize and debounce coin sensors, emit a one-cycle 2-bit coin code (1=5, 2=10).
// Latency: raw high first sampled at edge 1 -> in_code valid after edge DEBOUNCE_CYCLES+3.
// Backpressure: vend_busy high parks one coin in a 1-entry buffer (pending); further coins are dropped.
// Build option: define COIN_REJECT_EN to reject simultaneous 5/10 events and buffer-full arrivals
// with a one-cycle reject pulse; otherwise reject is tied low and 10 wins over 5.
module iiitb_coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  iiitb_coin_acceptor_if.slave    bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The debounced value flips on the edge the counter would reach DEBOUNCE_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  generate
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
      $error("iiitb_coin_acceptor: DEBOUNCE_CYCLES must be 1..255");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Index 0 is the 5-unit slot, index 1 the 10-unit slot.
  logic [1:0]          raw;
  logic [1:0]          sync1;
  logic [1:0]          sync2;
  logic [1:0]          deb;
  logic [1:0]          deb_d;
  logic [1:0][CW-1:0]  cnt;

  logic                ev5;
  logic                ev10;
  logic                ev_ok;
  logic [1:0]          ev_code;
`ifdef COIN_REJECT_EN
  logic                ev_both;
  logic                reject_d;
  logic                reject_q;
`endif

  state_t              state;
  state_t              state_nxt;
  logic [1:0]          buf_code;
  logic [1:0]          buf_nxt;
  logic [1:0]          in_code_d;
  logic [1:0]          in_code_q;
  logic                pending_d;
  logic                pending_q;

  assign raw = {bus.coin10_raw, bus.coin5_raw};

  // Two-flop synchronizer for the asynchronous sensor levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-slot debounce: count consecutive disagreeing cycles, any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb   <= 2'b00;
      deb_d <= 2'b00;
      cnt   <= '0;
    end else begin
      deb_d <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i] <= '0;
          deb[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Coin events are debounced rising edges only; falling edges mean the coin has left the slot.
  always_comb begin
    ev5     = deb[0] & ~deb_d[0];
    ev10    = deb[1] & ~deb_d[1];
    ev_code = ev10 ? 2'd2 : 2'd1;
`ifdef COIN_REJECT_EN
    ev_both = ev5 & ev10;
    ev_ok   = ev5 ^ ev10;
`else
    ev_ok   = ev5 | ev10;
`endif
  end

  // State and buffer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      buf_code <= 2'd0;
    end else begin
      state    <= state_nxt;
      buf_code <= buf_nxt;
    end
  end

  // Next state: EMIT behaves like IDLE so back-to-back coins are not lost; HOLD ignores new coins.
  always_comb begin
    state_nxt = state;
    buf_nxt   = buf_code;
    case (state)
      IDLE, EMIT: begin
        state_nxt = IDLE;
        if (ev_ok) begin
          if (bus.vend_busy) begin
            state_nxt = HOLD;
            buf_nxt   = ev_code;
          end else begin
            state_nxt = EMIT;
          end
        end
      end
      HOLD: begin
        if (!bus.vend_busy) begin
          state_nxt = EMIT;
          buf_nxt   = 2'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        buf_nxt   = 2'd0;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so they are registered alongside it.
  always_comb begin
    in_code_d = 2'd0;
    pending_d = (state_nxt == HOLD);
    if (state_nxt == EMIT) begin
      in_code_d = (state == HOLD) ? buf_code : ev_code;
    end
`ifdef COIN_REJECT_EN
    // In HOLD any arrival is one rejected coin event; elsewhere only a 5/10 collision is.
    reject_d = (state == HOLD) ? (ev5 | ev10) : ev_both;
`endif
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_code_q <= 2'd0;
      pending_q <= 1'b0;
`ifdef COIN_REJECT_EN
      reject_q  <= 1'b0;
`endif
    end else begin
      in_code_q <= in_code_d;
      pending_q <= pending_d;
`ifdef COIN_REJECT_EN
      reject_q  <= reject_d;
`endif
    end
  end

  assign bus.in_code = in_code_q;
  assign bus.pending = pending_q;
`ifdef COIN_REJECT_EN
  assign bus.reject  = reject_q;
`else
  assign bus.reject  = 1'b0;
`endif

endmodule

// File: doc/iiitb_coin_acceptor.md
IIITB_COIN_ACCEPTOR -- requirements
Module: iiitb_coin_acceptor

Upstream stage of the vending machine. It converts raw coin-slot sensor levels into the 2-bit coin code the machine samples each clock: 0 = none, 1 = 5-unit coin, 2 = 10-unit coin.

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4; number of consecutive synchronized cycles a raw level must hold before it is accepted (legal 1..255).
REQ-002 Port: clk, input, 1; sole clock, all state rising-edge.
REQ-003 Port: rst, input, 1; synchronous, active-high reset.
REQ-004 Port: coin5_raw, input, 1; asynchronous 5-unit slot sensor, high while coin present.
REQ-005 Port: coin10_raw, input, 1; asynchronous 10-unit slot sensor, high while coin present.
REQ-006 Port: vend_busy, input, 1; high while the downstream machine cannot accept a coin code.
REQ-007 Port: in_code, output, 2; registered coin code to the machine's `in`; value 3 never driven.
REQ-008 Port: pending, output, 1; high while one coin is buffered awaiting vend_busy low.
REQ-009 Port: reject, output, 1; registered one-cycle pulse per rejected coin event.

Function
REQ-010 Each raw input SHALL pass a 2-FF synchronizer, then a per-input debounce counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
REQ-011 Counter SHALL increment while the synchronized value differs from the debounced value, clear to 0 when they match, and update the debounced value on reaching DEBOUNCE_CYCLES.
REQ-012 A coin event SHALL be a 0->1 transition of a debounced value; 1->0 transitions SHALL generate nothing.
REQ-013 Latency: if raw is first sampled high at edge 1 and held, in_code SHALL become nonzero after edge DEBOUNCE_CYCLES+3, with vend_busy=0 and state IDLE.
REQ-014 FSM states: IDLE (in_code=0), EMIT (in_code=code, exactly one cycle), HOLD (in_code=0, pending=1).
REQ-015 IDLE + event + vend_busy=0 -> EMIT; IDLE + event + vend_busy=1 -> HOLD, code stored in a 1-entry buffer.
REQ-016 EMIT -> IDLE after one cycle; an event arriving in EMIT SHALL be treated as arriving in IDLE.
REQ-017 HOLD + vend_busy=0 -> EMIT with the buffered code; buffer cleared on the same edge.
REQ-018 Event while in HOLD (buffer full): coin SHALL NOT overwrite the buffer; it is rejected per REQ-025 / REQ-026.
REQ-019 vend_busy rising during EMIT SHALL NOT truncate the one-cycle in_code pulse.
REQ-020 Raw glitches shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no event, no reject and no counter carry-over.

Reset
REQ-021 On rst=1 at a clock edge: in_code=0, pending=0, reject=0, state=IDLE, buffer empty.
REQ-022 On that reset edge: synchronizers=0, debounced values=0, counters=0.
REQ-023 Reset mid-debounce or in HOLD SHALL discard the partial or buffered coin with no reject pulse.
REQ-024 A raw input still high after reset release SHALL be debounced afresh and produce one event.

Configuration
REQ-025 Macro COIN_REJECT_EN defined: simultaneous 5 and 10 events in one cycle SHALL both be rejected (in_code=0, one reject pulse). A coin arriving while the buffer is full SHALL give one reject pulse and be discarded.
REQ-026 COIN_REJECT_EN undefined: reject tied to 0. Simultaneous events SHALL be resolved as 10 wins and the 5 is dropped. Buffer-full arrivals are silently dropped.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Reset then coin5_raw high from edge 1 with vend_busy=0 -> in_code=1 for exactly one cycle after edge 7, then 0.
REQ-028 coin10_raw pulsed high for 2 cycles -> in_code stays 0, no reject.
REQ-029 vend_busy=1, coin10 event -> pending=1, in_code=0. Drop vend_busy -> in_code=2 for one cycle on the next edge, pending=0.
REQ-030 vend_busy=1, coin5 event then coin10 event -> in_code=1 after release. With COIN_REJECT_EN the coin10 gives a reject pulse; without it, no pulse.
REQ-031 coin5_raw and coin10_raw rise on the same edge -> with COIN_REJECT_EN: in_code=0 and one reject pulse; without it: in_code=2, reject=0.
REQ-032 rst asserted in HOLD -> pending=0 next cycle; in_code stays 0 after vend_busy drops.
